// File: rtl/fa_chunk_serial.sv
`default_nettype none
// ============================================================================
//  Module   : fa_chunk_serial
//  Purpose  : Multi-cycle adder. It adds WIDTH-bit operands CHUNK bits per
//             clock and ripples the carry between chunks through a carry
//             register. A start/done handshake brackets each operation.
//  Option   : FA_CHUNK_SUB_EN adds a `sub` input. When sub=1 the block
//             computes a + ~b + 1, ignores cin, and drives cout as not-borrow.
//  Revision : 1.0  initial release
// ============================================================================
module fa_chunk_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef FA_CHUNK_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [IW-1:0] c_LAST = IW'(NCH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  // Reject configurations in which the operand does not split into whole chunks.
  if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("fa_chunk_serial: WIDTH must be >= 1 and a multiple of CHUNK");
  end

  // Per-bit full-adder primitives.
  function automatic logic sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  logic [1:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;      // shifts right one chunk per RUN cycle
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_acc;    // completed chunks enter from the top
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  logic [WIDTH-1:0] w_b_in;
  logic             w_cin_in;
  logic [CHUNK-1:0] w_sum;
  logic             w_cy;
  logic [WIDTH-1:0] w_acc_next;

  // Subtraction is folded into the captured operands: invert b, force the carry-in.
`ifdef FA_CHUNK_SUB_EN
  assign w_b_in   = sub ? ~b : b;
  assign w_cin_in = sub ? 1'b1 : cin;
`else
  assign w_b_in   = b;
  assign w_cin_in = cin;
`endif

  // Ripple-add the low chunk of the shifting operand registers.
  always_comb begin
    w_sum = '0;
    w_cy  = r_carry;
    for (int i = 0; i < CHUNK; i++) begin
      w_sum[i] = sum(r_a[i], r_b[i], w_cy);
      w_cy     = carry(r_a[i], r_b[i], w_cy);
    end
  end

  // After NCH shifts, the first chunk computed sits in the least significant position.
  if (NCH == 1) begin : g_single
    assign w_acc_next = w_sum;
  end else begin : g_multi
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:CHUNK]};
  end

  // Sequencer: capture the operands, run NCH chunk steps, then publish the result for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_cin_in;
            r_idx   <= '0;
            r_state <= c_RUN;
          end else begin
            r_state <= c_IDLE;
          end
        end
        c_RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_cy;
          r_acc   <= w_acc_next;
          if (r_idx == c_LAST) begin
            r_s     <= w_acc_next;
            r_cout  <= w_cy;
            r_state <= c_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign busy = (r_state == c_RUN);
  assign done = (r_state == c_DONE);
  assign s    = r_s;
  assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_fa_chunk_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fa_chunk_serial
//  Purpose  : Scoreboard bench for fa_chunk_serial. It drives directed and
//             random operations. An independent monitor compares every done
//             pulse against an arithmetic reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fa_chunk_serial;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int NCH   = WIDTH / CHUNK;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             cout;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             busy, done, cout;
  logic [WIDTH-1:0] s;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   next_free = 0;
  int   busy_run = 0;
  bit   accepted;
  exp_t sbq[$];

  fa_chunk_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef FA_CHUNK_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: {cout,s} = a + b + cin, or a - b as a + ~b + 1 when subtracting.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic c, input logic sb);
    logic [WIDTH:0] r;
`ifdef FA_CHUNK_SUB_EN
    if (sb) r = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
    else    r = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
`else
    r = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c} + {{WIDTH{1'b0}}, sb & 1'b0};
`endif
    return r;
  endfunction

  // One clock. A free block takes start at the coming edge E and is next free at E+NCH+1.
  task automatic step();
    exp_t e;
    logic [WIDTH:0] r;
    accepted = 1'b0;
    if (rst_n && start && (cyc + 1) >= next_free) begin
      r      = model(a, b, cin, sub);
      e.s    = r[WIDTH-1:0];
      e.cout = r[WIDTH];
      e.cyc  = cyc + 1 + NCH;
      sbq.push_back(e);
      next_free = cyc + 1 + NCH + 1;
      accepted  = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present an operation with start held until it is accepted. Inputs stay as set afterwards.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic c, input logic sb);
    bit ok;
    ok    = 1'b0;
    a     = x;
    b     = y;
    cin   = c;
    sub   = sb;
    start = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      step();
      ok = accepted;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_accepted expected=accepted");
    end
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  // Monitor: every done pulse must match the oldest expected result at the predicted cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("sum",          32'(s),        32'(e.s));
          chk("cout",         32'(cout),     32'(e.cout));
          chk("done_latency", 32'(cyc),      32'(e.cyc));
          chk("busy_cycles",  32'(busy_run), 32'(NCH));
        end
        busy_run = 0;
      end
      if (busy) busy_run++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    // The reset state is held while rst_n is low.
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_s",    32'(s),    0);
    chk("rst_cout", 32'(cout), 0);
    rst_n = 1'b1;
    idle(3);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_s",    32'(s),    0);
    chk("idle_cout", 32'(cout), 0);

    // Directed cases: the carry crosses every chunk, then a carry-in with mixed digits.
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    idle(NCH + 2);
    issue(16'h1234, 16'h4321, 1'b1, 1'b0);
    idle(NCH + 2);

    // Back-to-back with start held. The operands change during RUN.
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
    issue(16'h8000, 16'h8000, 1'b0, 1'b0);
    idle(NCH + 2);

    // Abort in the second RUN cycle. No done pulse follows and the outputs clear.
    issue(16'h7777, 16'h1111, 1'b0, 1'b0);
    start = 1'b0;
    step();
    rst_n = 1'b0;
    sbq.delete();
    next_free = 0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_s",    32'(s),    0);
    chk("abort_cout", 32'(cout), 0);
    idle(2);
    rst_n = 1'b1;
    idle(NCH + 2);
    issue(16'h0F0F, 16'hF0F1, 1'b0, 1'b0);
    idle(NCH + 2);

`ifdef FA_CHUNK_SUB_EN
    issue(16'h0005, 16'h0007, 1'b1, 1'b1);
    idle(NCH + 2);
`endif

    // Random operations with random gaps. Some are back-to-back.
    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) ra = '1;
      issue(ra, rb, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        idle($urandom_range(0, NCH + 2));
      end
    end
    idle(1);

    // Drain the scoreboard, with a bounded wait.
    for (int k = 0; k < 40 && sbq.size() != 0; k++) step();
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d_pending expected=0_pending", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
